tcm_dport_arb: RTL and testbench



---
 rtl/tcm_arb_pkg.sv | 38 +++
 rtl/tcm_arb_src_fifo.sv | 66 ++++++
 rtl/tcm_dport_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_tcm_dport_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_arb_pkg.sv
// tcm_arb_pkg
// Shared definitions for the TCM data-port arbiter:
//   - master-ID constants (M_CORE, M_DMA)
//   - arbiter lock-state enumeration
//   - request-valid helper used for both masters
//   - source-FIFO pointer width helper and default derived width
package tcm_arb_pkg;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;

  localparam int OUTSTANDING_DEFAULT = 4;

  // Pointer width for a FIFO of the given depth; a depth of 1 still needs one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_PTR_W = fifo_ptr_w(OUTSTANDING_DEFAULT);

  // OPEN: grant follows the round-robin rules.
  // LOCK_*: a request is sitting on the downstream port waiting for accept.
  typedef enum logic [1:0] {
    ARB_OPEN      = 2'd0,
    ARB_LOCK_CORE = 2'd1,
    ARB_LOCK_DMA  = 2'd2
  } arb_state_e;

  // Any read, byte write or cache-maintenance operation counts as a request.
  function automatic logic req_valid(input logic       rd,
                                     input logic [3:0] wr,
                                     input logic       flush,
                                     input logic       invalidate,
                                     input logic       writeback);
    return rd | (|wr) | flush | invalidate | writeback;
  endfunction

endpackage

// File: rtl/tcm_arb_src_fifo.sv
// tcm_arb_src_fifo
// Remembers which master issued each accepted-but-unacknowledged request so
// in-order responses can be steered back to the right master.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       store push_id at the tail (ignored when full)
//   push_id    master ID of the accepted request
//   pop        drop the head entry (ignored when empty)
//   full       DEPTH entries held
//   empty      no entries held
//   head       master ID at the head
module tcm_arb_src_fifo
  import tcm_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop moves both pointers and leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tcm_dport_arb.sv
// tcm_dport_arb
// Round-robin arbiter letting the core data port (m0) and the DMA/loader (m1)
// share the single tcm_mem data port. Zero added latency: the downstream
// request is a mux of the granted master and responses are steered back
// through a source-ID FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_* / m1_*                   master request inputs, accept/ack/response outputs
//   s_*_o                         downstream request (mux of granted master)
//   s_accept_i, s_ack_i, ...      downstream handshake and in-order response
//   idle_o                        no outstanding requests and no locked grant
//   err_unexp_ack_o               sticky: an ack arrived with nothing outstanding
module tcm_dport_arb
  import tcm_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 11,
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  // master 0: riscv_core data port
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_wr_i,
  input  logic              m0_rd_i,
  input  logic [3:0]        m0_wr_i,
  input  logic              m0_cacheable_i,
  input  logic [TAG_W-1:0]  m0_req_tag_i,
  input  logic              m0_invalidate_i,
  input  logic              m0_writeback_i,
  input  logic              m0_flush_i,
  output logic              m0_accept_o,
  output logic              m0_ack_o,
  output logic              m0_error_o,
  output logic [DATA_W-1:0] m0_data_rd_o,
  output logic [TAG_W-1:0]  m0_resp_tag_o,
  // master 1: DMA / loader
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_wr_i,
  input  logic              m1_rd_i,
  input  logic [3:0]        m1_wr_i,
  input  logic              m1_cacheable_i,
  input  logic [TAG_W-1:0]  m1_req_tag_i,
  input  logic              m1_invalidate_i,
  input  logic              m1_writeback_i,
  input  logic              m1_flush_i,
  output logic              m1_accept_o,
  output logic              m1_ack_o,
  output logic              m1_error_o,
  output logic [DATA_W-1:0] m1_data_rd_o,
  output logic [TAG_W-1:0]  m1_resp_tag_o,
  // downstream (tcm_mem data port)
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_wr_o,
  output logic              s_rd_o,
  output logic [3:0]        s_wr_o,
  output logic              s_cacheable_o,
  output logic [TAG_W-1:0]  s_req_tag_o,
  output logic              s_invalidate_o,
  output logic              s_writeback_o,
  output logic              s_flush_o,
  input  logic              s_accept_i,
  input  logic              s_ack_i,
  input  logic              s_error_i,
  input  logic [DATA_W-1:0] s_data_rd_i,
  input  logic [TAG_W-1:0]  s_resp_tag_i,
  // status
  output logic              idle_o,
  output logic              err_unexp_ack_o
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic req0;
  logic req1;
  logic grant_valid;
  logic grant;
  logic drive;
  logic accept;
  logic sel;
  logic last_sel_q;
  logic rr_ptr_q;
  logic unexp_q;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic pop;
  logic unexp_ack;

  assign req0 = req_valid(m0_rd_i, m0_wr_i, m0_flush_i, m0_invalidate_i, m0_writeback_i);
  assign req1 = req_valid(m1_rd_i, m1_wr_i, m1_flush_i, m1_invalidate_i, m1_writeback_i);

  // A full source FIFO keeps the request off the downstream port entirely;
  // reset masks everything so no handshake can complete during it.
  assign drive  = grant_valid & ~fifo_full & ~rst;
  assign accept = drive & s_accept_i;

  // Lock-state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock is taken when a request is presented but not accepted, so the
  // downstream request cannot switch masters mid-handshake. It drops on the
  // accept cycle (or if the locked master withdraws its request).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_OPEN: begin
        if (drive && !s_accept_i) begin
          state_d = (grant == M_DMA) ? ARB_LOCK_DMA : ARB_LOCK_CORE;
        end
      end
      default: begin
        if (!grant_valid || accept) begin
          state_d = ARB_OPEN;
        end
      end
    endcase
  end

  // Grant selection: a locked master keeps the grant; otherwise a lone
  // requester wins and a tie goes to rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant       = M_CORE;
    unique case (state_q)
      ARB_LOCK_CORE: begin
        grant       = M_CORE;
        grant_valid = req0;
      end
      ARB_LOCK_DMA: begin
        grant       = M_DMA;
        grant_valid = req1;
      end
      default: begin
        if (req0 && req1) begin
          grant       = rr_ptr_q;
          grant_valid = 1'b1;
        end else if (req0) begin
          grant       = M_CORE;
          grant_valid = 1'b1;
        end else if (req1) begin
          grant       = M_DMA;
          grant_valid = 1'b1;
        end
      end
    endcase
  end

  // Round-robin pointer flips to the other master after every accept; the
  // last selected master keeps the non-strobe fields steady while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= M_CORE;
      last_sel_q <= M_CORE;
    end else begin
      if (accept) begin
        rr_ptr_q <= ~grant;
      end
      if (grant_valid) begin
        last_sel_q <= grant;
      end
    end
  end

  assign sel = grant_valid ? grant : last_sel_q;

  assign s_addr_o       = (sel == M_DMA) ? m1_addr_i      : m0_addr_i;
  assign s_data_wr_o    = (sel == M_DMA) ? m1_data_wr_i   : m0_data_wr_i;
  assign s_cacheable_o  = (sel == M_DMA) ? m1_cacheable_i : m0_cacheable_i;
  assign s_req_tag_o    = (sel == M_DMA) ? m1_req_tag_i   : m0_req_tag_i;
  assign s_rd_o         = drive & ((sel == M_DMA) ? m1_rd_i         : m0_rd_i);
  assign s_wr_o         = drive ? ((sel == M_DMA) ? m1_wr_i : m0_wr_i) : 4'b0000;
  assign s_flush_o      = drive & ((sel == M_DMA) ? m1_flush_i      : m0_flush_i);
  assign s_invalidate_o = drive & ((sel == M_DMA) ? m1_invalidate_i : m0_invalidate_i);
  assign s_writeback_o  = drive & ((sel == M_DMA) ? m1_writeback_i  : m0_writeback_i);

  assign m0_accept_o = accept & (grant == M_CORE);
  assign m1_accept_o = accept & (grant == M_DMA);

  tcm_arb_src_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_src_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (accept),
    .push_id(grant),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Responses come back in order, so the FIFO head names their owner.
  assign pop       = s_ack_i & ~fifo_empty & ~rst;
  assign unexp_ack = s_ack_i & fifo_empty & ~rst;

  assign m0_ack_o      = pop & (fifo_head == M_CORE);
  assign m1_ack_o      = pop & (fifo_head == M_DMA);
  assign m0_error_o    = m0_ack_o & s_error_i;
  assign m1_error_o    = m1_ack_o & s_error_i;
  assign m0_data_rd_o  = m0_ack_o ? s_data_rd_i  : '0;
  assign m1_data_rd_o  = m1_ack_o ? s_data_rd_i  : '0;
  assign m0_resp_tag_o = m0_ack_o ? s_resp_tag_i : '0;
  assign m1_resp_tag_o = m1_ack_o ? s_resp_tag_i : '0;

  // Sticky flag for acks that match no outstanding request; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      unexp_q <= 1'b0;
    end else if (unexp_ack) begin
      unexp_q <= 1'b1;
    end
  end

  assign err_unexp_ack_o = unexp_q;
  assign idle_o          = rst | (fifo_empty & (state_q == ARB_OPEN));

endmodule

// File: tb/tb_tcm_dport_arb.sv
// tb_tcm_dport_arb
// Randomized and directed stimulus for tcm_dport_arb, checked every cycle
// against a behavioural model: a queue of issuing-master IDs, a round-robin
// pointer and a locked-master index.
module tb_tcm_dport_arb;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TAG_W       = 11;
  localparam int OUTSTANDING = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;

  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [DATA_W-1:0] m0_data_wr_i, m1_data_wr_i;
  logic              m0_rd_i, m1_rd_i;
  logic [3:0]        m0_wr_i, m1_wr_i;
  logic              m0_cacheable_i, m1_cacheable_i;
  logic [TAG_W-1:0]  m0_req_tag_i, m1_req_tag_i;
  logic              m0_invalidate_i, m1_invalidate_i;
  logic              m0_writeback_i, m1_writeback_i;
  logic              m0_flush_i, m1_flush_i;
  logic              m0_accept_o, m1_accept_o;
  logic              m0_ack_o, m1_ack_o;
  logic              m0_error_o, m1_error_o;
  logic [DATA_W-1:0] m0_data_rd_o, m1_data_rd_o;
  logic [TAG_W-1:0]  m0_resp_tag_o, m1_resp_tag_o;

  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_wr_o;
  logic              s_rd_o;
  logic [3:0]        s_wr_o;
  logic              s_cacheable_o;
  logic [TAG_W-1:0]  s_req_tag_o;
  logic              s_invalidate_o, s_writeback_o, s_flush_o;
  logic              s_accept_i, s_ack_i, s_error_i;
  logic [DATA_W-1:0] s_data_rd_i;
  logic [TAG_W-1:0]  s_resp_tag_i;
  logic              idle_o, err_unexp_ack_o;

  always #5 clk = ~clk;

  tcm_dport_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i),
    .m0_wr_i(m0_wr_i), .m0_cacheable_i(m0_cacheable_i), .m0_req_tag_i(m0_req_tag_i),
    .m0_invalidate_i(m0_invalidate_i), .m0_writeback_i(m0_writeback_i), .m0_flush_i(m0_flush_i),
    .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o), .m0_error_o(m0_error_o),
    .m0_data_rd_o(m0_data_rd_o), .m0_resp_tag_o(m0_resp_tag_o),
    .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i),
    .m1_wr_i(m1_wr_i), .m1_cacheable_i(m1_cacheable_i), .m1_req_tag_i(m1_req_tag_i),
    .m1_invalidate_i(m1_invalidate_i), .m1_writeback_i(m1_writeback_i), .m1_flush_i(m1_flush_i),
    .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o), .m1_error_o(m1_error_o),
    .m1_data_rd_o(m1_data_rd_o), .m1_resp_tag_o(m1_resp_tag_o),
    .s_addr_o(s_addr_o), .s_data_wr_o(s_data_wr_o), .s_rd_o(s_rd_o), .s_wr_o(s_wr_o),
    .s_cacheable_o(s_cacheable_o), .s_req_tag_o(s_req_tag_o),
    .s_invalidate_o(s_invalidate_o), .s_writeback_o(s_writeback_o), .s_flush_o(s_flush_o),
    .s_accept_i(s_accept_i), .s_ack_i(s_ack_i), .s_error_i(s_error_i),
    .s_data_rd_i(s_data_rd_i), .s_resp_tag_i(s_resp_tag_i),
    .idle_o(idle_o), .err_unexp_ack_o(err_unexp_ack_o)
  );

  // Pending request per master, held until the model says it was accepted.
  logic              p_valid[2];
  logic [ADDR_W-1:0] p_addr[2];
  logic [DATA_W-1:0] p_wdata[2];
  logic              p_rd[2];
  logic [3:0]        p_wr[2];
  logic              p_cache[2];
  logic [TAG_W-1:0]  p_tag[2];
  logic              p_inv[2];
  logic              p_wb[2];
  logic              p_flush[2];

  // Downstream behaviour for the current cycle.
  logic              t_acc, t_ack, t_err;
  logic [DATA_W-1:0] t_rdata;
  logic [TAG_W-1:0]  t_rtag;

  // Reference model state.
  int src_q[$];
  int mdl_lock = -1;
  int mdl_rr   = 0;
  bit mdl_err  = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic driveInputs();
    m0_addr_i       = p_addr[0];
    m0_data_wr_i    = p_wdata[0];
    m0_rd_i         = p_valid[0] & p_rd[0];
    m0_wr_i         = p_valid[0] ? p_wr[0] : 4'b0000;
    m0_cacheable_i  = p_cache[0];
    m0_req_tag_i    = p_tag[0];
    m0_invalidate_i = p_valid[0] & p_inv[0];
    m0_writeback_i  = p_valid[0] & p_wb[0];
    m0_flush_i      = p_valid[0] & p_flush[0];
    m1_addr_i       = p_addr[1];
    m1_data_wr_i    = p_wdata[1];
    m1_rd_i         = p_valid[1] & p_rd[1];
    m1_wr_i         = p_valid[1] ? p_wr[1] : 4'b0000;
    m1_cacheable_i  = p_cache[1];
    m1_req_tag_i    = p_tag[1];
    m1_invalidate_i = p_valid[1] & p_inv[1];
    m1_writeback_i  = p_valid[1] & p_wb[1];
    m1_flush_i      = p_valid[1] & p_flush[1];
    s_accept_i      = t_acc;
    s_ack_i         = t_ack;
    s_error_i       = t_err;
    s_data_rd_i     = t_rdata;
    s_resp_tag_i    = t_rtag;
  endtask

  // kind: 0 read, 1 write, 2 flush, 3 invalidate, 4 writeback
  task automatic setReq(input int m, input int kind, input logic [ADDR_W-1:0] addr,
                        input logic [TAG_W-1:0] tag);
    p_valid[m] = 1'b1;
    p_addr[m]  = addr;
    p_wdata[m] = $urandom;
    p_rd[m]    = (kind == 0);
    p_wr[m]    = (kind == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
    p_flush[m] = (kind == 2);
    p_inv[m]   = (kind == 3);
    p_wb[m]    = (kind == 4);
    p_cache[m] = 1'($urandom_range(0, 1));
    p_tag[m]   = tag;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic applyStimulus();
    int g;
    bit gv;
    bit drv;
    int head;
    @(negedge clk);
    rst = 1'b0;
    driveInputs();
    #1;
    gv = 1'b0;
    g  = 0;
    if (mdl_lock >= 0) begin
      g  = mdl_lock;
      gv = p_valid[g];
    end else if (p_valid[0] && p_valid[1]) begin
      g  = mdl_rr;
      gv = 1'b1;
    end else if (p_valid[0]) begin
      g  = 0;
      gv = 1'b1;
    end else if (p_valid[1]) begin
      g  = 1;
      gv = 1'b1;
    end
    drv = gv && (src_q.size() < OUTSTANDING);

    checkOutput("m0_accept", 64'(m0_accept_o), 64'(drv && t_acc && g == 0));
    checkOutput("m1_accept", 64'(m1_accept_o), 64'(drv && t_acc && g == 1));
    checkOutput("s_strobes",
                64'({s_rd_o, s_wr_o, s_flush_o, s_invalidate_o, s_writeback_o}),
                drv ? 64'({p_rd[g], p_wr[g], p_flush[g], p_inv[g], p_wb[g]}) : 64'd0);
    if (drv) begin
      checkOutput("s_addr", 64'(s_addr_o), 64'(p_addr[g]));
      checkOutput("s_data_wr", 64'(s_data_wr_o), 64'(p_wdata[g]));
      checkOutput("s_req_tag", 64'(s_req_tag_o), 64'(p_tag[g]));
      checkOutput("s_cacheable", 64'(s_cacheable_o), 64'(p_cache[g]));
    end

    head = (src_q.size() > 0) ? src_q[0] : -1;
    checkOutput("m0_ack", 64'(m0_ack_o), 64'(t_ack && head == 0));
    checkOutput("m1_ack", 64'(m1_ack_o), 64'(t_ack && head == 1));
    if (t_ack && head == 0) begin
      checkOutput("m0_data_rd", 64'(m0_data_rd_o), 64'(t_rdata));
      checkOutput("m0_resp_tag", 64'(m0_resp_tag_o), 64'(t_rtag));
      checkOutput("m0_error", 64'(m0_error_o), 64'(t_err));
    end else if (t_ack && head == 1) begin
      checkOutput("m1_data_rd", 64'(m1_data_rd_o), 64'(t_rdata));
      checkOutput("m1_resp_tag", 64'(m1_resp_tag_o), 64'(t_rtag));
      checkOutput("m1_error", 64'(m1_error_o), 64'(t_err));
    end
    checkOutput("idle", 64'(idle_o), 64'(src_q.size() == 0 && mdl_lock < 0));
    checkOutput("err_unexp", 64'(err_unexp_ack_o), 64'(mdl_err));

    @(posedge clk);
    if (t_ack) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      else mdl_err = 1'b1;
    end
    if (drv && t_acc) begin
      src_q.push_back(g);
      mdl_rr     = 1 - g;
      mdl_lock   = -1;
      p_valid[g] = 1'b0;
    end else if (drv) begin
      mdl_lock = g;
    end else if (mdl_lock >= 0 && !p_valid[mdl_lock]) begin
      mdl_lock = -1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      p_valid[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0; p_rd[m] = 1'b0;
      p_wr[m] = 4'b0; p_cache[m] = 1'b0; p_tag[m] = '0;
      p_inv[m] = 1'b0; p_wb[m] = 1'b0; p_flush[m] = 1'b0;
    end
    t_acc = 1'b1; t_ack = 1'b0; t_err = 1'b0; t_rdata = '0; t_rtag = '0;
    driveInputs();
    #1;
    checkOutput("rst_m0_accept", 64'(m0_accept_o), 64'd0);
    checkOutput("rst_m1_accept", 64'(m1_accept_o), 64'd0);
    checkOutput("rst_m0_ack", 64'(m0_ack_o), 64'd0);
    checkOutput("rst_m1_ack", 64'(m1_ack_o), 64'd0);
    checkOutput("rst_idle", 64'(idle_o), 64'd1);
    checkOutput("rst_m0_data", 64'(m0_data_rd_o), 64'd0);
    checkOutput("rst_m1_tag", 64'(m1_resp_tag_o), 64'd0);
    @(posedge clk);
    src_q.delete();
    mdl_lock = -1;
    mdl_rr   = 0;
    mdl_err  = 1'b0;
  endtask

  task automatic randomDownstream(input int acc_pct, input int ack_pct);
    t_acc   = ($urandom_range(0, 99) < acc_pct);
    t_ack   = (src_q.size() > 0) && ($urandom_range(0, 99) < ack_pct);
    t_err   = 1'($urandom_range(0, 1));
    t_rdata = $urandom;
    t_rtag  = TAG_W'($urandom);
  endtask

  task automatic runPhase(input int cycles, input int req_pct, input int acc_pct, input int ack_pct);
    for (int i = 0; i < cycles; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_valid[m] && $urandom_range(0, 99) < req_pct)
          setReq(m, $urandom_range(0, 4), $urandom, TAG_W'($urandom));
      end
      randomDownstream(acc_pct, ack_pct);
      applyStimulus();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      randomDownstream(100, 100);
      applyStimulus();
    end
  endtask

  initial begin
    $display("[TB] tcm_dport_arb bench start");
    doReset();

    // Lone core read, then its response with a fixed tag and data.
    setReq(0, 0, 32'h8000_0100, 11'h005);
    t_acc = 1'b1; t_ack = 1'b0;
    applyStimulus();
    t_ack = 1'b1; t_rdata = 32'hCAFE_F00D; t_rtag = 11'h005; t_err = 1'b0;
    applyStimulus();

    // Both masters always requesting, downstream always accepting.
    runPhase(16, 100, 100, 40);
    drain();

    // Slow downstream accept: exercises the lock.
    runPhase(30, 100, 25, 40);
    drain();

    // Fill the source FIFO with back-to-back core writes, no acks.
    for (int i = 0; i < 6; i++) begin
      if (!p_valid[0]) setReq(0, 1, 32'h0000_1000 + 32'(i * 4), TAG_W'(i));
      t_acc = 1'b1; t_ack = 1'b0;
      applyStimulus();
    end
    t_ack = 1'b1; t_rdata = $urandom; t_rtag = '0;
    applyStimulus();
    t_ack = 1'b0;
    applyStimulus();
    drain();

    // Unexpected ack with nothing outstanding; the flag must stick.
    t_ack = 1'b1;
    applyStimulus();
    t_ack = 1'b0;
    runPhase(10, 60, 80, 50);

    // Reset with three requests outstanding, then a stale ack.
    drain();
    doReset();
    for (int i = 0; i < 3; i++) begin
      setReq(0, 1, 32'h0000_2000 + 32'(i * 4), TAG_W'(i));
      t_acc = 1'b1; t_ack = 1'b0;
      applyStimulus();
    end
    doReset();
    t_ack = 1'b1;
    applyStimulus();
    setReq(0, 0, 32'h0000_3000, 11'h011);
    setReq(1, 0, 32'h0000_3004, 11'h022);
    t_ack = 1'b0; t_acc = 1'b1;
    applyStimulus();
    applyStimulus();

    // Long random soak.
    runPhase(300, 50, 70, 50);
    runPhase(200, 80, 90, 30);
    runPhase(200, 40, 50, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
